// File: rtl/traffic_light_pkg.sv
// Shared types for the N-way intersection controller: FSM state encoding,
// lamp codes and the round-robin next-approach search.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } tl_state_e;

    localparam logic [2:0] LAMP_R = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b100;

    localparam int MAX_DIR = 8;

    // First approach with demand after cur, wrapping modulo n.
    // With no demand anywhere the plain rotation cur+1 is chosen.
    function automatic logic [2:0] rr_next(
        input logic [MAX_DIR-1:0] demand,
        input logic [2:0]         cur,
        input int                 n
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = 3'((int'(cur) + 1) % n);
        found = 1'b0;
        for (int k = 1; k <= MAX_DIR; k++) begin
            idx = (int'(cur) + k) % n;
            if (!found && k <= n && demand[idx[2:0]]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Lamp/sensor bundle of one junction. master = board/testbench side,
// slave = controller. TL_PREEMPT_EN adds preempt and preempt_dir.
interface traffic_light_ctrl_if #(
    parameter int NUM_DIR = 4
);
    logic                   tick;
    logic [NUM_DIR-1:0]     car_present;
    logic [NUM_DIR-1:0]     ped_req;
    logic [3*NUM_DIR-1:0]   lamp;
    logic [NUM_DIR-1:0]     walk;
    logic [2:0]             active_dir;
    logic [NUM_DIR-1:0]     ped_pending;
`ifdef TL_PREEMPT_EN
    logic                   preempt;
    logic [2:0]             preempt_dir;

    modport master (
        output tick, car_present, ped_req,
        output preempt, preempt_dir,
        input  lamp, walk, active_dir, ped_pending
    );
    modport slave (
        input  tick, car_present, ped_req,
        input  preempt, preempt_dir,
        output lamp, walk, active_dir, ped_pending
    );
`else
    modport master (
        output tick, car_present, ped_req,
        input  lamp, walk, active_dir, ped_pending
    );
    modport slave (
        input  tick, car_present, ped_req,
        output lamp, walk, active_dir, ped_pending
    );
`endif
endinterface

// File: rtl/tl_phase_timer.sv
// Tick-enabled saturating phase timer with clear and terminal compares.
// Ports: clk, reset_n, tick, clr in; allred_done/yellow_done/green_min/green_max out.
module tl_phase_timer #(
    parameter int CNT_W     = 8,
    parameter int GREEN_T   = 20,
    parameter int GREEN_MAX = 60,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic clr,
    output logic allred_done,
    output logic yellow_done,
    output logic green_min,
    output logic green_max
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (tick && count != '1)
            count <= count + 1'b1;
    end

    assign allred_done = count == CNT_W'(ALLRED_T - 1);
    assign yellow_done = count == CNT_W'(YELLOW_T - 1);
    assign green_min   = count >= CNT_W'(GREEN_T - 1);
    // >= so a long preempt hold (saturated timer) still counts as expired
    assign green_max   = count >= CNT_W'(GREEN_MAX - 1);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin N-way junction controller: FSM, pedestrian latch, lamp/walk regs.
// Ports: clk, reset_n (async, active-low), bus (slave: tick, car_present,
// ped_req in; lamp, walk, active_dir, ped_pending out). Macro: TL_PREEMPT_EN.
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int NUM_DIR   = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_T   = 20,
    parameter int GREEN_MAX = 60,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input logic                  clk,
    input logic                  reset_n,
    traffic_light_ctrl_if.slave  bus
);
    tl_state_e            state_q, state_d;
    logic [2:0]           dir_q, dir_d, rr_dir, sel_dir;
    logic [NUM_DIR-1:0]   pend_q, pend_d, demand, other;
    logic [NUM_DIR-1:0]   dir_oh, next_oh;
    logic [MAX_DIR-1:0]   demand_x;
    logic                 walk_en_q, ent_green, tmr_clr;
    logic                 leave_green, norm_leave;
    logic                 allred_done, yellow_done;
    logic                 green_min, green_max;
    logic [3*NUM_DIR-1:0] lamp_d, lamp_q;
    logic [NUM_DIR-1:0]   walk_d, walk_q;
    logic [2:0]           act_q;

    tl_phase_timer #(
        .CNT_W     (CNT_W),
        .GREEN_T   (GREEN_T),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (bus.tick),
        .clr         (tmr_clr),
        .allred_done (allred_done),
        .yellow_done (yellow_done),
        .green_min   (green_min),
        .green_max   (green_max)
    );

    always_comb begin
        for (int i = 0; i < NUM_DIR; i++) begin
            dir_oh[i]  = dir_q == 3'(i);
            next_oh[i] = dir_d == 3'(i);
        end
    end

    assign demand   = bus.car_present | pend_q;
    assign other    = demand & ~dir_oh;
    assign demand_x = MAX_DIR'(demand);
    assign rr_dir   = rr_next(demand_x, dir_q, NUM_DIR);

    // Exits are evaluated on the pre-increment timer of the same tick
    assign norm_leave = bus.tick && ((green_min && |other) || green_max);

`ifdef TL_PREEMPT_EN
    // Preempting a foreign green is immediate; the preempted
    // approach's own green is held regardless of GREEN_MAX.
    assign leave_green = bus.preempt ? (bus.preempt_dir != dir_q)
                                     : norm_leave;
    assign sel_dir     = bus.preempt ? bus.preempt_dir : rr_dir;
`else
    assign leave_green = norm_leave;
    assign sel_dir     = rr_dir;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ALL_RED;
            dir_q     <= '0;
            pend_q    <= '0;
            walk_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            if (ent_green)
                walk_en_q <= |(pend_q & next_oh);
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        tmr_clr   = 1'b0;
        ent_green = 1'b0;
        unique case (state_q)
            ALL_RED: if (bus.tick && allred_done) begin
                state_d   = GREEN;
                dir_d     = sel_dir;
                tmr_clr   = 1'b1;
                ent_green = 1'b1;
            end
            GREEN: if (leave_green) begin
                state_d = YELLOW;
                tmr_clr = 1'b1;
            end
            YELLOW: if (bus.tick && yellow_done) begin
                state_d = ALL_RED;
                tmr_clr = 1'b1;
            end
            default: begin
                state_d = ALL_RED;
                tmr_clr = 1'b1;
            end
        endcase
    end

    // A new request ORed after the clear: set wins over clear
    assign pend_d = (pend_q & ~(ent_green ? next_oh : '0))
                  | bus.ped_req;

    always_comb begin
        lamp_d = {NUM_DIR{LAMP_R}};
        walk_d = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (dir_oh[i]) begin
                unique case (1'b1)
                    (state_q == GREEN): begin
                        lamp_d[3*i +: 3] = LAMP_G;
                        walk_d[i]        = walk_en_q;
                    end
                    (state_q == YELLOW):
                        lamp_d[3*i +: 3] = LAMP_Y;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lamp_q <= {NUM_DIR{LAMP_R}};
            walk_q <= '0;
            act_q  <= '0;
        end else begin
            lamp_q <= lamp_d;
            walk_q <= walk_d;
            act_q  <= dir_q;
        end
    end

    assign bus.lamp        = lamp_q;
    assign bus.walk        = walk_q;
    assign bus.active_dir  = act_q;
    assign bus.ped_pending = pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: expected lamp phases (dir, colour, length,
// walk, pending) are queued per segment and checked as each phase ends.
module tb_traffic_light_ctrl;

    localparam int ND = 4;
    localparam logic [2:0] CR = 3'b001;
    localparam logic [2:0] CY = 3'b010;
    localparam logic [2:0] CG = 3'b100;

    typedef struct {
        logic [ND-1:0] car;
        logic [ND-1:0] ped;
        int            dly;
        int            dir;
        logic [2:0]    col;
        int            len;
        logic [ND-1:0] walk;
        logic [ND-1:0] pend;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;

    traffic_light_ctrl_if #(.NUM_DIR(ND)) bus();

    traffic_light_ctrl #(
        .NUM_DIR   (ND),
        .CNT_W     (8),
        .GREEN_T   (20),
        .GREEN_MAX (60),
        .YELLOW_T  (4),
        .ALLRED_T  (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    vec_t          sb[$];
    int            seg_idx = 0;
    bit            mon_en = 0;
    bit            started = 0;
    int            pdir, cd, len, nr;
    logic [2:0]    pcol, cc;
    logic [ND-1:0] walk_or, pend_last;
    bit            bad;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic void classify(input logic [3*ND-1:0] l,
                                     output int d,
                                     output logic [2:0] c);
        d = 0;
        c = CR;
        for (int i = 0; i < ND; i++)
            if (l[3*i +: 3] != CR) begin
                d = i;
                c = l[3*i +: 3];
            end
    endfunction

    task automatic end_seg();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL seg%0d unexpected: dir %0d col %b",
                     seg_idx, pdir, pcol);
        end else begin
            e = sb.pop_front();
            checks++;
            if (pcol != e.col || (e.col != CR && pdir != e.dir)) begin
                errors++;
                $display("FAIL seg%0d phase: got dir %0d col %b want dir %0d col %b",
                         seg_idx, pdir, pcol, e.dir, e.col);
            end
            chk($sformatf("seg%0d walk", seg_idx), 32'(walk_or), 32'(e.walk));
            if (e.len != 0) begin
                chk($sformatf("seg%0d len", seg_idx), 32'(len), 32'(e.len));
                chk($sformatf("seg%0d pend", seg_idx),
                    32'(pend_last), 32'(e.pend));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            classify(bus.lamp, cd, cc);
            nr  = 0;
            bad = 0;
            for (int i = 0; i < ND; i++) begin
                if (bus.lamp[3*i +: 3] != CR) nr++;
                if (!(bus.lamp[3*i +: 3] inside {CR, CY, CG})) bad = 1;
            end
            checks++;
            if (nr > 1 || bad) begin
                errors++;
                $display("FAIL invariant: lamp %h non-R count %0d", bus.lamp, nr);
            end
            if (!started) begin
                started = 1;
                pdir = cd; pcol = cc; len = 1; walk_or = bus.walk;
            end else if (cd != pdir || cc != pcol) begin
                end_seg();
                seg_idx++;
                pdir = cd; pcol = cc; len = 1; walk_or = bus.walk;
            end else begin
                len++;
                walk_or |= bus.walk;
            end
            pend_last = bus.ped_pending;
        end
    end

    initial begin
        vec_t v[17];
        vec_t r17;
        bit   abort;
        int   n;
        int   gd;
        logic [2:0] gc;

        v[0]  = '{4'b0001, 4'b0000, 0, 0, CR,  0, 4'b0000, 4'b0000};
        v[1]  = '{4'b0001, 4'b0000, 0, 0, CG, 60, 4'b0000, 4'b0000};
        v[2]  = '{4'b0000, 4'b0000, 0, 0, CY,  4, 4'b0000, 4'b0000};
        v[3]  = '{4'b0000, 4'b0000, 0, 0, CR,  2, 4'b0000, 4'b0000};
        v[4]  = '{4'b0000, 4'b1010, 3, 1, CG, 20, 4'b0000, 4'b1010};
        v[5]  = '{4'b0000, 4'b0000, 0, 1, CY,  4, 4'b0000, 4'b1010};
        v[6]  = '{4'b0000, 4'b0000, 0, 0, CR,  2, 4'b0000, 4'b0010};
        v[7]  = '{4'b0000, 4'b0000, 0, 3, CG, 20, 4'b1000, 4'b0010};
        v[8]  = '{4'b0000, 4'b0000, 0, 3, CY,  4, 4'b0000, 4'b0010};
        v[9]  = '{4'b0000, 4'b0000, 0, 0, CR,  2, 4'b0000, 4'b0000};
        v[10] = '{4'b0001, 4'b0000, 0, 1, CG, 20, 4'b0010, 4'b0000};
        v[11] = '{4'b0001, 4'b0000, 0, 1, CY,  4, 4'b0000, 4'b0000};
        v[12] = '{4'b0001, 4'b0000, 0, 0, CR,  2, 4'b0000, 4'b0000};
        v[13] = '{4'b0101, 4'b0000, 5, 0, CG, 20, 4'b0000, 4'b0000};
        v[14] = '{4'b0100, 4'b0000, 0, 0, CY,  4, 4'b0000, 4'b0000};
        v[15] = '{4'b0100, 4'b0000, 0, 0, CR,  2, 4'b0000, 4'b0000};
        v[16] = '{4'b0100, 4'b0001, 3, 2, CG,  0, 4'b0000, 4'b0000};
        r17   = '{4'b0100, 4'b0000, 0, 0, CR,  0, 4'b0000, 4'b0000};

        abort           = 0;
        reset_n         = 1'b0;
        bus.tick        = 1'b1;
        bus.car_present = 4'b0001;
        bus.ped_req     = '0;
`ifdef TL_PREEMPT_EN
        bus.preempt     = 1'b0;
        bus.preempt_dir = 3'd0;
`endif
        repeat (3) @(negedge clk);
        chk("rst lamp", 32'(bus.lamp), 32'({ND{CR}}));
        chk("rst walk", 32'(bus.walk), 32'(0));
        chk("rst active", 32'(bus.active_dir), 32'(0));
        chk("rst pend", 32'(bus.ped_pending), 32'(0));
        reset_n = 1'b1;
        mon_en  = 1;

        for (int i = 0; i < 17 && !abort; i++) begin
            n = 0;
            while (seg_idx != i && n < 200) begin
                @(negedge clk); #1;
                n++;
            end
            if (seg_idx != i) begin
                errors++;
                $display("FAIL seg%0d timeout: at seg %0d", i, seg_idx);
                abort = 1;
            end else begin
                sb.push_back(v[i]);
                repeat (v[i].dly) begin
                    @(negedge clk); #1;
                end
                bus.car_present = v[i].car;
                if (v[i].ped != '0) begin
                    bus.ped_req = v[i].ped;
                    @(negedge clk); #1;
                    bus.ped_req = '0;
                end
            end
        end

        if (!abort) begin
            sb.push_back(r17);
            repeat (4) begin
                @(negedge clk); #1;
            end
            reset_n = 1'b0;
            #1;
            chk("midrst lamp", 32'(bus.lamp), 32'({ND{CR}}));
            chk("midrst pend", 32'(bus.ped_pending), 32'(0));
            chk("midrst walk", 32'(bus.walk), 32'(0));
            chk("midrst active", 32'(bus.active_dir), 32'(0));
            @(negedge clk); #1;
            reset_n = 1'b1;
            n = 0;
            do begin
                @(negedge clk); #1;
                n++;
                classify(bus.lamp, gd, gc);
            end while (gc != CG && n < 10);
            chk("recover cycles", 32'(n), 32'(3));
            chk("recover dir", 32'(bus.active_dir), 32'(2));
            chk("recover lamp", 32'(bus.lamp[8:6]), 32'(CG));
            chk("sb drained", 32'(sb.size()), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
